// File: rtl/gd_job_sequencer_if.sv
// gd_job_sequencer_if: job, engine and result signals of the gradient-descent job sequencer.
// master: the sequencer itself (accepts jobs, drives the engine, presents results).
// slave:  the surrounding environment (job source, engine and result sink).
interface gd_job_sequencer_if #(
  parameter int unsigned N = 16
) ();
  // Job submission
  logic         job_valid;
  logic         job_ready;
  logic [N-1:0] job_x;
  logic [N-1:0] job_alpha;
  logic [N-1:0] job_a;
  logic [N-1:0] job_b;

  // Engine start/ready
  logic         eng_start;
  logic [N-1:0] eng_x;
  logic [N-1:0] eng_alpha;
  logic [N-1:0] eng_a;
  logic [N-1:0] eng_b;
  logic         eng_ready;
  logic [N-1:0] eng_x_next;

  // Result return
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_x;
  logic [7:0]   res_tag;
  logic         res_err;

  logic         busy;

  modport master (
    input  job_valid, job_x, job_alpha, job_a, job_b,
    output job_ready,
    output eng_start, eng_x, eng_alpha, eng_a, eng_b,
    input  eng_ready, eng_x_next,
    output res_valid, res_x, res_tag, res_err,
    input  res_ready,
    output busy
  );

  modport slave (
    output job_valid, job_x, job_alpha, job_a, job_b,
    input  job_ready,
    input  eng_start, eng_x, eng_alpha, eng_a, eng_b,
    output eng_ready, eng_x_next,
    input  res_valid, res_x, res_tag, res_err,
    output res_ready,
    input  busy
  );
endinterface

// File: rtl/gd_job_sequencer.sv
// gd_job_sequencer: queues gradient-descent jobs in a DEPTH-entry FIFO, issues them one at a
// time to an external engine over a start/ready handshake and returns results in issue order.
// Optional feature: define GDS_TIMEOUT_EN to add an engine watchdog of TIMEOUT WAIT cycles.
module gd_job_sequencer #(
  parameter int unsigned N       = 16,
  parameter int unsigned M       = 8,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  gd_job_sequencer_if.master bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] PtrOne = 1;

  // M is a format annotation only; it and the other parameters are sanity-checked here.
  if ((M >= N) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1))
  begin : g_param_check
    $error("gd_job_sequencer: invalid parameter set");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResult} state_e;

  state_e r_state;
  state_e w_next_state;

  logic [N-1:0] r_fifo_x     [DEPTH];
  logic [N-1:0] r_fifo_alpha [DEPTH];
  logic [N-1:0] r_fifo_a     [DEPTH];
  logic [N-1:0] r_fifo_b     [DEPTH];
  logic [7:0]   r_fifo_tag   [DEPTH];

  logic [PtrW:0]   r_wptr;
  logic [PtrW:0]   r_rptr;
  logic [PtrW-1:0] w_widx;
  logic [PtrW-1:0] w_ridx;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_qualify;
  logic            w_timeout;

  logic [7:0]   r_tag;
  logic [N-1:0] r_eng_x;
  logic [N-1:0] r_eng_alpha;
  logic [N-1:0] r_eng_a;
  logic [N-1:0] r_eng_b;
  logic         r_wait_first;
  logic [N-1:0] r_res_x;
  logic [7:0]   r_res_tag;

  assign w_widx  = r_wptr[PtrW-1:0];
  assign w_ridx  = r_rptr[PtrW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PtrW] != r_rptr[PtrW]) && (w_widx == w_ridx);
  // Fullness is judged before any same-cycle pop, so a full FIFO always refuses.
  assign w_push  = bus.job_valid && !w_full;
  // A done level seen in ISSUE or the first WAIT cycle may belong to the previous job.
  assign w_qualify = (r_state == StWait) && bus.eng_ready && !r_wait_first;
  assign w_pop     = w_qualify || w_timeout;

`ifdef GDS_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  logic [TmoW-1:0] r_tmo_cnt;
  logic            r_res_err;

  assign w_timeout = (r_state == StWait) && !w_qualify && (r_tmo_cnt == TmoW'(TIMEOUT - 1));

  // Count WAIT cycles of the in-flight job; cleared while issuing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StIssue) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StWait) begin
      r_tmo_cnt <= r_tmo_cnt + TmoW'(1);
    end
  end

  // Error flag of the presented result: set only when the watchdog fired.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_err <= 1'b0;
    end else if (w_qualify) begin
      r_res_err <= 1'b0;
    end else if (w_timeout) begin
      r_res_err <= 1'b1;
    end
  end
`else
  logic r_res_err;

  assign w_timeout = 1'b0;
  assign r_res_err = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:   if (!w_empty) w_next_state = StIssue;
      StIssue:  w_next_state = StWait;
      StWait:   if (w_pop) w_next_state = StResult;
      StResult: if (bus.res_ready) w_next_state = StIdle;
      default:  w_next_state = StIdle;
    endcase
  end

  // FSM and FIFO status outputs.
  always_comb begin
    bus.job_ready = !w_full;
    bus.eng_start = (r_state == StIssue);
    bus.res_valid = (r_state == StResult);
    bus.busy      = !w_empty || (r_state != StIdle);
  end

  assign bus.eng_x     = r_eng_x;
  assign bus.eng_alpha = r_eng_alpha;
  assign bus.eng_a     = r_eng_a;
  assign bus.eng_b     = r_eng_b;
  assign bus.res_x     = r_res_x;
  assign bus.res_tag   = r_res_tag;
  assign bus.res_err   = r_res_err;

  // Job storage; contents need no reset since occupancy lives in the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_x[w_widx]     <= bus.job_x;
      r_fifo_alpha[w_widx] <= bus.job_alpha;
      r_fifo_a[w_widx]     <= bus.job_a;
      r_fifo_b[w_widx]     <= bus.job_b;
      r_fifo_tag[w_widx]   <= r_tag;
    end
  end

  // FIFO pointers and the per-accept tag counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_tag  <= 8'd0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PtrOne;
        r_tag  <= r_tag + 8'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrOne;
      end
    end
  end

  // Latch the head job as engine operands on the IDLE->ISSUE transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_eng_x     <= '0;
      r_eng_alpha <= '0;
      r_eng_a     <= '0;
      r_eng_b     <= '0;
    end else if ((r_state == StIdle) && !w_empty) begin
      r_eng_x     <= r_fifo_x[w_ridx];
      r_eng_alpha <= r_fifo_alpha[w_ridx];
      r_eng_a     <= r_fifo_a[w_ridx];
      r_eng_b     <= r_fifo_b[w_ridx];
    end
  end

  // Marks the first WAIT cycle, during which eng_ready is masked.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_first <= 1'b0;
    end else begin
      r_wait_first <= (r_state == StIssue);
    end
  end

  // Capture the result and head tag as the head job leaves WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_x   <= '0;
      r_res_tag <= 8'd0;
    end else if (w_qualify) begin
      r_res_x   <= bus.eng_x_next;
      r_res_tag <= r_fifo_tag[w_ridx];
    end else if (w_timeout) begin
      r_res_x   <= r_fifo_x[w_ridx];
      r_res_tag <= r_fifo_tag[w_ridx];
    end
  end

endmodule

// File: tb/tb_gd_job_sequencer.sv
// tb_gd_job_sequencer: random and directed stimulus against a timestamp-based reference model
// of the job sequencer, with a 12-cycle engine model that can hold a stale done level.
module tb_gd_job_sequencer;

  localparam int unsigned N       = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int          EngLat  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  gd_job_sequencer_if #(.N(N)) u_if ();

  gd_job_sequencer #(
    .N      (N),
    .M      (8),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Value the engine returns for a given operand set.
  function automatic logic [15:0] eng_fn(input logic [15:0] x, input logic [15:0] al,
                                          input logic [15:0] a, input logic [15:0] b);
    return x ^ {al[7:0], a[15:8]} ^ (b + 16'h1357);
  endfunction

  // ---------------- engine model ----------------
  bit          stale_mode = 1'b0;
  bit          mute_mode  = 1'b0;
  bit          fixed_en   = 1'b0;
  logic [15:0] fixed_val  = 16'h0;
  logic [3:0]  eng_cnt;
  logic        eng_drop;

  always @(posedge clk) begin
    if (rst) begin
      eng_cnt          <= 4'd0;
      eng_drop         <= 1'b0;
      u_if.eng_ready   <= 1'b0;
      u_if.eng_x_next  <= 16'h0;
    end else if (u_if.eng_start) begin
      eng_cnt  <= mute_mode ? 4'd0 : 4'(EngLat - 1);
      eng_drop <= stale_mode;
      if (!stale_mode) u_if.eng_ready <= 1'b0;
      u_if.eng_x_next <= fixed_en ? fixed_val
                                  : eng_fn(u_if.eng_x, u_if.eng_alpha, u_if.eng_a, u_if.eng_b);
    end else begin
      // Stale mode keeps done high until one cycle into the next job's WAIT.
      if (eng_drop || !stale_mode) u_if.eng_ready <= 1'b0;
      eng_drop <= 1'b0;
      if (eng_cnt != 4'd0) begin
        eng_cnt <= eng_cnt - 4'd1;
        if (eng_cnt == 4'd1) u_if.eng_ready <= 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] x;
    logic [15:0] al;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  tag;
    logic [15:0] ret;
    bit          err;
    int          acc;
  } job_t;

  job_t       q[$];
  int         cyc = 0;
  bit         m_inflight = 1'b0;
  int         m_issue = 0;
  int         m_res = 0;
  int         m_free = 0;
  logic [7:0] m_tag = 8'd0;
  bit         exp_start;
  bit         exp_valid;
  bit         exp_ready;
  int         m_popped;

  always @(posedge clk) cyc <= cyc + 1;

  // A job accepted in cycle c issues at max(c+2, last handshake+2); its result appears
  // 13 cycles after issue (or TIMEOUT+1 on a watchdog expiry) and stays until consumed.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        m_inflight = 1'b0;
        m_tag      = 8'd0;
        m_free     = cyc;
      end else begin
        if (!m_inflight && (q.size() > 0)) begin
          m_issue    = (q[0].acc + 2 > m_free + 2) ? q[0].acc + 2 : m_free + 2;
          m_res      = m_issue + (q[0].err ? TIMEOUT + 1 : EngLat + 1);
          m_inflight = 1'b1;
        end
        exp_start = m_inflight && (cyc == m_issue);
        exp_valid = m_inflight && (cyc >= m_res);
        m_popped  = exp_valid ? 1 : 0;
        exp_ready = (q.size() - m_popped) < DEPTH;

        check_eq("eng_start", u_if.eng_start, exp_start);
        check_eq("res_valid", u_if.res_valid, exp_valid);
        check_eq("job_ready", u_if.job_ready, exp_ready);
        check_eq("busy", u_if.busy, q.size() > 0);
        if (m_inflight && (cyc >= m_issue) && (cyc < m_res)) begin
          check_eq("eng_x", u_if.eng_x, q[0].x);
          check_eq("eng_alpha", u_if.eng_alpha, q[0].al);
          check_eq("eng_a", u_if.eng_a, q[0].a);
          check_eq("eng_b", u_if.eng_b, q[0].b);
        end
        if (exp_valid) begin
          check_eq("res_x", u_if.res_x, q[0].ret);
          check_eq("res_tag", u_if.res_tag, q[0].tag);
          check_eq("res_err", u_if.res_err, q[0].err);
          if (u_if.res_ready) begin
            q.delete(0);
            m_inflight = 1'b0;
            m_free     = cyc;
          end
        end
        if (u_if.job_valid && exp_ready) begin
          job_t j;
          j.x   = u_if.job_x;
          j.al  = u_if.job_alpha;
          j.a   = u_if.job_a;
          j.b   = u_if.job_b;
          j.tag = m_tag;
          j.err = mute_mode;
          j.ret = mute_mode ? u_if.job_x
                            : (fixed_en ? fixed_val
                                        : eng_fn(u_if.job_x, u_if.job_alpha, u_if.job_a,
                                                 u_if.job_b));
          j.acc = cyc;
          q.push_back(j);
          m_tag = m_tag + 8'd1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply_reset();
    rst            = 1'b1;
    u_if.job_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Offer one job until accepted; returns 1 ns after the accepting edge.
  task automatic push_job(input logic [15:0] x, input logic [15:0] al, input logic [15:0] a,
                          input logic [15:0] b);
    int k;
    u_if.job_valid = 1'b1;
    u_if.job_x     = x;
    u_if.job_alpha = al;
    u_if.job_a     = a;
    u_if.job_b     = b;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!u_if.job_ready && (k < 200));
    if (k >= 200) check_eq("push_wait", u_if.job_ready, 1'b1);
    @(posedge clk);
    #1 u_if.job_valid = 1'b0;
  endtask

  task automatic push_rand();
    push_job(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic wait_res(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!u_if.res_valid && (k < 200));
  endtask

  int k;

  initial begin
    u_if.job_valid = 1'b0;
    u_if.job_x     = 16'h0;
    u_if.job_alpha = 16'h0;
    u_if.job_a     = 16'h0;
    u_if.job_b     = 16'h0;
    u_if.res_ready = 1'b0;
    apply_reset();

    // Reset state
    @(negedge clk);
    check_eq("rst_job_ready", u_if.job_ready, 1'b1);
    check_eq("rst_busy", u_if.busy, 1'b0);
    check_eq("rst_eng_start", u_if.eng_start, 1'b0);
    check_eq("rst_res_valid", u_if.res_valid, 1'b0);
    check_eq("rst_eng_ops", {u_if.eng_x, u_if.eng_alpha}, 32'h0);
    check_eq("rst_eng_ab", {u_if.eng_a, u_if.eng_b}, 32'h0);
    check_eq("rst_res", {u_if.res_x, u_if.res_tag, 7'd0, u_if.res_err}, 32'h0);

    // Single job with a programmed engine result
    @(posedge clk);
    #1;
    u_if.res_ready = 1'b1;
    fixed_en       = 1'b1;
    fixed_val      = 16'h0080;
    push_job(16'h0100, 16'h0100, 16'h0100, 16'hFF00);
    wait_res(k);
    check_eq("single_latency", k, 15);
    check_eq("single_res_x", u_if.res_x, 16'h0080);
    check_eq("single_res_tag", u_if.res_tag, 8'd0);
    check_eq("single_res_err", u_if.res_err, 1'b0);
    @(posedge clk);
    #1 fixed_en = 1'b0;
    repeat (5) @(posedge clk);

    // Back-pressure: five jobs into a four-deep FIFO with results stalled
    apply_reset();
    u_if.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_rand();
      if (i == 3) begin
        @(negedge clk);
        check_eq("bp_full", u_if.job_ready, 1'b0);
        @(posedge clk);
        #1;
      end
    end
    repeat (20) @(negedge clk);
    check_eq("bp_held_valid", u_if.res_valid, 1'b1);
    check_eq("bp_held_tag", u_if.res_tag, 8'd0);
    @(posedge clk);
    #1 u_if.res_ready = 1'b1;
    repeat (100) @(posedge clk);

    // Stale done level between jobs
    #1 stale_mode = 1'b1;
    for (int i = 0; i < 3; i++) push_rand();
    repeat (70) @(posedge clk);
    #1 stale_mode = 1'b0;
    repeat (5) @(posedge clk);

    // Reset while in WAIT with three jobs queued
    #1;
    push_rand();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!u_if.eng_start && (k < 50));
    check_eq("rw_start_seen", u_if.eng_start, 1'b1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) push_rand();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rw_busy", u_if.busy, 1'b0);
    check_eq("rw_job_ready", u_if.job_ready, 1'b1);
    check_eq("rw_res_valid", u_if.res_valid, 1'b0);
    check_eq("rw_eng_x", u_if.eng_x, 16'h0);
    repeat (30) @(negedge clk);
    @(posedge clk);
    #1;
    push_rand();
    wait_res(k);
    check_eq("rw_next_tag", u_if.res_tag, 8'd0);
    repeat (5) @(posedge clk);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      if ((i % 200) == 0) stale_mode = 1'($urandom_range(0, 1));
      u_if.job_valid = ($urandom_range(0, 2) == 0);
      u_if.job_x     = 16'($urandom);
      u_if.job_alpha = 16'($urandom);
      u_if.job_a     = 16'($urandom);
      u_if.job_b     = 16'($urandom);
      u_if.res_ready = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    u_if.job_valid = 1'b0;
    u_if.res_ready = 1'b1;
    stale_mode     = 1'b0;
    repeat (200) @(posedge clk);

`ifdef GDS_TIMEOUT_EN
    // Engine never answers: watchdog returns the job's own x with the error flag
    #1 mute_mode = 1'b1;
    push_job(16'h7FFF, 16'($urandom), 16'($urandom), 16'($urandom));
    wait_res(k);
    check_eq("tmo_latency", k, TIMEOUT + 3);
    check_eq("tmo_res_x", u_if.res_x, 16'h7FFF);
    check_eq("tmo_res_err", u_if.res_err, 1'b1);
    @(posedge clk);
    #1 mute_mode = 1'b0;
    push_rand();
    wait_res(k);
    check_eq("tmo_next_err", u_if.res_err, 1'b0);
    repeat (10) @(posedge clk);
`endif

    @(negedge clk);
    check_eq("drain_busy", u_if.busy, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
